softmax_seq_div: RTL and testbench
==================================

# softmax_seq_div

Length-masked, fixed-point, base-2 softmax with parametrised lane count and input format. It is the successor to the 64-lane FP16 softmax and sits in the same attention datapath slot, between score generation and the value-weighting stage. Unlike its predecessor, it honours `i_length_mode` by masking inactive lanes. It replaces the reciprocal IP with a shared, iterative restoring divider controlled by an FSM, and processes one vector at a time.

## Interface
- `N`, 64: lane count; power of two, 2..64.
- `IW`, 16: input width; signed two's-complement logit, already scaled by log2(e).
- `FRAC`, 8: input fraction bits; 1..14.
- `clk`  in  1  clock; everything is on the rising edge.
- `rst_n`  in  1  reset; asynchronous, active-low.
- `i_length_mode`  in  4  active length selector: L = N >> mode; a mode above log2(N) clamps to L = 1; sampled at input accept.
- `x_in`  in  N*IW  input logits; lane i is at `[i*IW +: IW]`.
- `x_in_valid`  in  1  input valid.
- `softmax_ready`  out  1  block can accept an input vector.
- `next_ready`  in  1  downstream can accept a result.
- `softmax_valid`  out  1  result valid.
- `softmax`  out  N*16  unsigned Q1.15 probabilities (0x8000 = 1.0); lane i is at `[i*16 +: 16]`.

## Operation
- FSM states: IDLE, MAX, EXP, SUM, DIV, MUL, OUT.
- IDLE: `softmax_ready` = 1. On `x_in_valid` & `softmax_ready`, register `x_in` and L, then go to MAX. `softmax_ready` is 0 in every other state.
- MAX (1 cycle): m = signed maximum of lanes 0..L-1. Lanes at index L and above are ignored.
- EXP (1 cycle), for each active lane:
  - d = m − x_i, an unsigned value of IW+1 bits.
  - k = d >> FRAC and f = d[FRAC-1:0].
  - mant = 32768 − (f << (14−FRAC)).
  - e_i = (k ≥ 16) ? 0 : mant >> k.
  - Inactive lanes: e_i = 0.
- SUM (1 cycle): S = Σe_i at full width, 16 + log2(N) bits. S ≥ 32768 is guaranteed because the max lane contributes 32768.
- DIV (exactly 16 cycles): R = floor(2^30 / S), computed by a restoring divider producing 1 quotient bit per cycle, MSB first, with a 4-bit counter. R ≤ 32768, so it fits in 16 bits.
- MUL (1 cycle): y_i = (e_i × R) >> 15, truncated, 16 bits. Inactive lanes are 0.
- OUT: `softmax_valid` = 1 and `softmax` holds y. On `next_ready`, go to IDLE. While `next_ready` = 0, stay in OUT with output stable.
- Arithmetic is truncating everywhere. No rounding, no saturation is needed (all values are bounded as above).

## Timing
- Reset values:
  - State = IDLE.
  - `softmax_ready` = 1 (IDLE; tracks reset release).
  - `softmax_valid` = 0.
  - `softmax` = 0.
  - All internal registers = 0.
- Latency: if the accept happens on edge 0, `softmax_valid` rises after edge 20. That is 1 (MAX) + 1 (EXP) + 1 (SUM) + 16 (DIV) + 1 (MUL).
- Throughput: one vector per 22 cycles at best. The OUT handshake edge returns the FSM to IDLE, and the next accept happens on the following edge.
- `softmax_valid` never drops without a `next_ready` handshake. `softmax` does not change while valid and stalled.
- `x_in`, `x_in_valid` and `i_length_mode` are don't-care outside IDLE; an input presented while busy is not accepted.
- Asserting `rst_n` low mid-vector (any state):
  - Abort immediately: state goes to IDLE, `softmax_valid` = 0, `softmax` = 0.
  - The partial vector is discarded and nothing is emitted after release.
- A result handshake and a new input in the same cycle: the input is not accepted in that cycle, because `softmax_ready` = 0 in OUT.

## Test plan
- L = 1 (mode = 6, N = 64), lane0 = 0x8123, other lanes arbitrary -> y0 = 0x8000, all other lanes 0x0000, valid 20 cycles after accept.
- Mode = 5 (L = 2), x0 = x1 = 0x0040 -> y0 = y1 = 0x4000 (S = 65536, R = 16384), lanes 2..63 = 0.
- Mode = 5, x0 = 0x0100, x1 = 0x0000 -> e1 = 16384, S = 49152, R = 21845, y0 = 0x5555, y1 = 0x2AAA.
- Mode = 5, x0 = 0x0080, x1 = 0x0000 (d = 0.5) -> e1 = 24576, S = 57344, R = 18724, y0 = 0x4924, y1 = 0x36DB. Repeat with x1 = 0x8000 (k ≥ 16) -> y0 = 0x8000, y1 = 0.
- Mode = 0, all 64 lanes equal -> every y_i = 0x0200. Hold `next_ready` = 0 for 10 cycles -> valid and data stay stable and `softmax_ready` stays 0. Then release and present a back-to-back vector -> accepted 1 cycle after the handshake.
- Pull `rst_n` low during DIV, then release and send a new vector with mode = 6 -> no stale output appears, and the new result (0x8000 in lane0) comes 20 cycles after accept.

Source files
------------

// File: rtl/softmax_seq_div.sv
// softmax_seq_div: length-masked fixed-point base-2 softmax, one vector at a time.
// Pipeline of FSM states IDLE -> MAX -> EXP -> SUM -> DIV(16) -> MUL -> OUT.
// Ports:
//   clk, rst_n       clock (rising edge), asynchronous active-low reset
//   i_length_mode    active length L = N >> mode (clamped to 1), sampled at accept
//   x_in             N signed IW-bit logits (log2(e)-scaled, FRAC fraction bits)
//   x_in_valid       input valid; accepted only while softmax_ready
//   softmax_ready    high in IDLE
//   next_ready       downstream accepts result
//   softmax_valid    high in OUT; result held until next_ready
//   softmax          N unsigned Q1.15 probabilities, inactive lanes 0
module softmax_seq_div #(
  parameter int N    = 64,
  parameter int IW   = 16,
  parameter int FRAC = 8
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [3:0]      i_length_mode,
  input  logic [N*IW-1:0] x_in,
  input  logic            x_in_valid,
  output logic            softmax_ready,
  input  logic            next_ready,
  output logic            softmax_valid,
  output logic [N*16-1:0] softmax
);

  localparam int LOGN = $clog2(N);
  localparam int LW   = LOGN + 1;
  localparam int SW   = 16 + LOGN;
  localparam int RW   = SW + 1;

  typedef enum logic [2:0] {IDLE, MAX, EXP, SUM, DIV, MUL, OUT} state_t;

  state_t state, state_next;

  logic [N*IW-1:0]       x_reg;
  logic [N-1:0]          act;
  logic signed [IW-1:0]  m;
  logic [15:0]           e [N];
  logic [SW-1:0]         s;
  logic [SW-1:0]         rem;
  logic [15:0]           q;
  logic [3:0]            cnt;
  logic [N*16-1:0]       y;

  logic [LW-1:0]         len_in;
  logic [N-1:0]          act_in;
  logic signed [IW-1:0]  m_c;
  logic [15:0]           e_c [N];
  logic [SW-1:0]         s_c;
  logic [RW-1:0]         trial;
  logic                  ge;
  logic [N*16-1:0]       y_c;

  // ---------------- control ----------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: if (x_in_valid) state_next = MAX;
      MAX:  state_next = EXP;
      EXP:  state_next = SUM;
      SUM:  state_next = DIV;
      DIV:  if (cnt == 4'd15) state_next = MUL;
      MUL:  state_next = OUT;
      OUT:  if (next_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  assign softmax_ready = (state == IDLE);
  assign softmax_valid = (state == OUT);
  assign softmax       = y;

  // ---------------- datapath (combinational) ----------------
  // Lane mask: modes beyond log2(N) would shift N to zero, so clamp to one lane.
  always_comb begin
    len_in = (i_length_mode >= 4'(LOGN)) ? LW'(1) : (LW'(N) >> i_length_mode);
    act_in = '0;
    for (int unsigned i = 0; i < N; i++) act_in[i] = (LW'(i) < len_in);
  end

  // Lane 0 is always active, so it seeds the maximum.
  always_comb begin
    m_c = x_reg[IW-1:0];
    for (int unsigned i = 1; i < N; i++)
      if (act[i] && ($signed(x_reg[i*IW +: IW]) > m_c)) m_c = x_reg[i*IW +: IW];
  end

  // 2^-d with d = k + f: linear mantissa 1 - f/2 in Q1.15, shifted by the integer part.
  always_comb begin
    logic [IW-1:0]   xi;
    logic [IW:0]     d;
    logic [31:0]     k;
    logic [FRAC-1:0] f;
    logic [15:0]     mant;
    xi   = '0;
    d    = '0;
    k    = '0;
    f    = '0;
    mant = '0;
    for (int unsigned i = 0; i < N; i++) begin
      xi   = x_reg[i*IW +: IW];
      d    = {m[IW-1], m} - {xi[IW-1], xi};
      k    = 32'(d) >> FRAC;
      f    = d[FRAC-1:0];
      mant = 16'h8000 - (16'(f) << (14 - FRAC));
      e_c[i] = (!act[i] || (k >= 32'd16)) ? '0 : (mant >> k[3:0]);
    end
  end

  always_comb begin
    s_c = '0;
    for (int unsigned i = 0; i < N; i++) s_c = s_c + SW'(e[i]);
  end

  // Restoring division of 2^30 by S: the remainder starts at 2^30 >> 16 and the
  // remaining dividend bits are all zero, so each step is just a shift and trial subtract.
  always_comb begin
    trial = {rem, 1'b0};
    ge    = (trial >= {1'b0, s});
  end

  always_comb begin
    y_c = '0;
    for (int unsigned i = 0; i < N; i++)
      y_c[i*16 +: 16] = 16'((32'(e[i]) * 32'(q)) >> 15);
  end

  // ---------------- datapath (registers) ----------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x_reg <= '0;
      act   <= '0;
      m     <= '0;
      for (int unsigned i = 0; i < N; i++) e[i] <= '0;
      s     <= '0;
      rem   <= '0;
      q     <= '0;
      cnt   <= '0;
      y     <= '0;
    end else begin
      case (state)
        IDLE: if (x_in_valid) begin
          x_reg <= x_in;
          act   <= act_in;
        end
        MAX: m <= m_c;
        EXP: for (int unsigned i = 0; i < N; i++) e[i] <= e_c[i];
        SUM: begin
          s   <= s_c;
          rem <= SW'(1) << 14;
          q   <= '0;
          cnt <= '0;
        end
        DIV: begin
          rem <= ge ? SW'(trial - {1'b0, s}) : SW'(trial);
          q   <= {q[14:0], ge};
          cnt <= cnt + 4'd1;
        end
        MUL: y <= y_c;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_softmax_seq_div.sv
module tb_softmax_seq_div;
  localparam int N    = 64;
  localparam int IW   = 16;
  localparam int FRAC = 8;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [3:0]      mode;
  logic [N*IW-1:0] x_in;
  logic            x_in_valid;
  logic            softmax_ready;
  logic            next_ready;
  logic            softmax_valid;
  logic [N*16-1:0] softmax;

  int pass_cnt = 0;
  int fail_cnt = 0;
  int total    = 0;
  int lat;
  int vhigh;

  always #5 clk = ~clk;

  softmax_seq_div #(.N(N), .IW(IW), .FRAC(FRAC)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .i_length_mode(mode),
    .x_in(x_in),
    .x_in_valid(x_in_valid),
    .softmax_ready(softmax_ready),
    .next_ready(next_ready),
    .softmax_valid(softmax_valid),
    .softmax(softmax)
  );

  function automatic logic [N*IW-1:0] fill(input logic [15:0] a, input logic [15:0] b,
                                           input logic [15:0] r);
    logic [N*IW-1:0] v;
    v = '0;
    for (int i = 0; i < N; i++) v[i*IW +: IW] = (i == 0) ? a : (i == 1) ? b : r;
    return v;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) pass_cnt++;
    else begin
      fail_cnt++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_lanes(input string tag, input logic [15:0] y0, input logic [15:0] y1);
    logic [15:0] ex;
    for (int i = 0; i < N; i++) begin
      ex = (i == 0) ? y0 : (i == 1) ? y1 : 16'h0000;
      check($sformatf("%s_y%0d", tag, i), 32'(softmax[i*16 +: 16]), 32'(ex));
    end
  endtask

  task automatic check_all(input string tag, input logic [15:0] v);
    for (int i = 0; i < N; i++)
      check($sformatf("%s_y%0d", tag, i), 32'(softmax[i*16 +: 16]), 32'(v));
  endtask

  // Starts and ends on a falling edge; the accept is the rising edge in between.
  task automatic send(input logic [3:0] md, input logic [N*IW-1:0] vec);
    x_in       = vec;
    mode       = md;
    x_in_valid = 1'b1;
    check("ready_before_accept", 32'(softmax_ready), 32'd1);
    @(posedge clk);
    @(negedge clk);
    x_in_valid = 1'b0;
    x_in       = fill(16'h7FFF, 16'h7FFF, 16'h7FFF);
    check("ready_after_accept", 32'(softmax_ready), 32'd0);
  endtask

  // Counts rising edges after the accept edge until valid is seen; bounded.
  task automatic wait_valid(output int cyc);
    cyc = 0;
    while (softmax_valid !== 1'b1 && cyc < 60) begin
      @(posedge clk);
      cyc++;
      @(negedge clk);
    end
  endtask

  task automatic handshake();
    next_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    next_ready = 1'b0;
    check("valid_after_hs", 32'(softmax_valid), 32'd0);
    check("ready_after_hs", 32'(softmax_ready), 32'd1);
  endtask

  task automatic run(input string tag, input logic [3:0] md, input logic [N*IW-1:0] vec,
                     input logic [15:0] y0, input logic [15:0] y1);
    send(md, vec);
    wait_valid(lat);
    check({tag, "_latency"}, 32'(lat), 32'd20);
    check_lanes(tag, y0, y1);
    handshake();
  endtask

  initial begin
    rst_n      = 1'b0;
    mode       = '0;
    x_in       = '0;
    x_in_valid = 1'b0;
    next_ready = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_ready", 32'(softmax_ready), 32'd1);
    check("rst_valid", 32'(softmax_valid), 32'd0);
    check_all("rst", 16'h0000);
    rst_n = 1'b1;
    @(negedge clk);

    // Single active lane; inactive lanes larger than lane 0 must be ignored.
    run("l1",    4'd6,  fill(16'h8123, 16'h7FFF, 16'h7FFF), 16'h8000, 16'h0000);
    run("eq2",   4'd5,  fill(16'h0040, 16'h0040, 16'h7FFF), 16'h4000, 16'h4000);
    run("d1",    4'd5,  fill(16'h0100, 16'h0000, 16'h7FFF), 16'h5555, 16'h2AAA);
    run("dhalf", 4'd5,  fill(16'h0080, 16'h0000, 16'h7FFF), 16'h4924, 16'h36DB);
    run("k16",   4'd5,  fill(16'h0080, 16'h8000, 16'h7FFF), 16'h8000, 16'h0000);
    run("clamp", 4'd15, fill(16'h0000, 16'h7FFF, 16'h7FFF), 16'h8000, 16'h0000);

    // All 64 lanes equal, then a 10-cycle stall.
    send(4'd0, fill(16'h0155, 16'h0155, 16'h0155));
    wait_valid(lat);
    check("all64_latency", 32'(lat), 32'd20);
    check_all("all64", 16'h0200);
    for (int c = 0; c < 10; c++) begin
      @(posedge clk);
      @(negedge clk);
      check($sformatf("stall%0d_valid", c), 32'(softmax_valid), 32'd1);
      check($sformatf("stall%0d_ready", c), 32'(softmax_ready), 32'd0);
      check($sformatf("stall%0d_y0", c),  32'(softmax[0*16 +: 16]),  32'h0200);
      check($sformatf("stall%0d_y31", c), 32'(softmax[31*16 +: 16]), 32'h0200);
      check($sformatf("stall%0d_y63", c), 32'(softmax[63*16 +: 16]), 32'h0200);
    end

    // Handshake with a new input already presented: refused on the handshake edge,
    // accepted on the following one.
    x_in       = fill(16'h1234, 16'h7FFF, 16'h7FFF);
    mode       = 4'd6;
    x_in_valid = 1'b1;
    next_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    next_ready = 1'b0;
    check("b2b_valid_drop", 32'(softmax_valid), 32'd0);
    check("b2b_ready_idle", 32'(softmax_ready), 32'd1);
    @(posedge clk);
    @(negedge clk);
    x_in_valid = 1'b0;
    check("b2b_accepted", 32'(softmax_ready), 32'd0);
    wait_valid(lat);
    check("b2b_latency", 32'(lat), 32'd20);
    check_lanes("b2b", 16'h8000, 16'h0000);
    handshake();

    // Reset while dividing.
    send(4'd5, fill(16'h0100, 16'h0000, 16'h7FFF));
    repeat (8) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("arst_valid", 32'(softmax_valid), 32'd0);
    check("arst_ready", 32'(softmax_ready), 32'd1);
    check_all("arst", 16'h0000);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    vhigh = 0;
    for (int c = 0; c < 30; c++) begin
      @(negedge clk);
      if (softmax_valid !== 1'b0) vhigh++;
    end
    check("arst_no_stale", 32'(vhigh), 32'd0);
    check("arst_idle", 32'(softmax_ready), 32'd1);
    run("post", 4'd6, fill(16'h0ABC, 16'h7FFF, 16'h7FFF), 16'h8000, 16'h0000);

    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

endmodule
